// File: rtl/arp_ctrl.sv
// arp_ctrl - ARP protocol sequencer.
// Sits between the ARP receive analyser and the ARP transmit packer. It
// schedules outgoing ARP requests and replies onto the single packer, retries
// unanswered requests after RETRY_TIME cycles, gives up after MAX_RETRY
// transmissions, and holds the resolved PC MAC address.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         pulse: resolve (or refresh) the PC MAC address
//   ack_en        pulse: valid ARP request for our IP received, reply needed
//   get_en        pulse: valid ARP reply received, get_mac_pc holds its MAC
//   get_mac_pc    sender MAC from the analyser (valid with get_en)
//   tx_start      pulse to the packer: build and send a packet
//   tx_op         packet type for the packer (0 = request, 1 = reply)
//   tx_done       pulse from the packer: packet fully sent
//   mac_pc        latched PC MAC address
//   mac_valid     mac_pc holds a resolved address
//   arp_fail      pulse: MAX_RETRY requests sent with no reply
//   busy          pending work, transmission in flight or reply wait active
module arp_ctrl #(
  parameter int MAC_ADDR_W = 48,
  parameter int TIME_W     = 32,
  parameter int RETRY_TIME = 12500000,
  parameter int MAX_RETRY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ack_en,
  input  logic                  get_en,
  input  logic [MAC_ADDR_W-1:0] get_mac_pc,
  output logic                  tx_start,
  output logic                  tx_op,
  input  logic                  tx_done,
  output logic [MAC_ADDR_W-1:0] mac_pc,
  output logic                  mac_valid,
  output logic                  arp_fail,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, TX_REQ, TX_ACK} state_t;

  state_t            state_q, state_d;
  logic              ack_pend_q, req_pend_q, awaiting_q;
  logic [TIME_W-1:0] timer_q;
  logic [3:0]        retry_cnt_q;

  logic enter_req, enter_ack, req_done;
  logic timeout, retry_ok, retry_hit, fail_hit;

  assign timeout   = awaiting_q && (timer_q == TIME_W'(RETRY_TIME - 1));
  assign retry_ok  = retry_cnt_q < 4'(MAX_RETRY);
  // A reply arriving on the timeout cycle cancels both retry and failure.
  assign retry_hit = timeout && !get_en && retry_ok;
  assign fail_hit  = timeout && !get_en && !retry_ok;

  // State register plus the registered launch strobe and packet type
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_start <= 1'b0;
      tx_op    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_start <= enter_req | enter_ack;
      if (enter_req | enter_ack) tx_op <= enter_ack;
    end
  end

  // Next-state logic; a pending reply always beats a pending request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ack_pend_q)      state_d = TX_ACK;
        else if (req_pend_q) state_d = TX_REQ;
      end
      TX_REQ, TX_ACK: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / decode logic, derived only from registered state
  always_comb begin
    enter_req = (state_q == IDLE) && (state_d == TX_REQ);
    enter_ack = (state_q == IDLE) && (state_d == TX_ACK);
    req_done  = (state_q == TX_REQ) && tx_done;
    busy      = (state_q != IDLE) | ack_pend_q | req_pend_q | awaiting_q;
  end

  // Pending flags, reply wait timer, retry counter and MAC latch.
  // Later assignments win: get_en overrides timeout, start overrides get_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pend_q  <= 1'b0;
      req_pend_q  <= 1'b0;
      awaiting_q  <= 1'b0;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      mac_pc      <= '0;
      mac_valid   <= 1'b0;
      arp_fail    <= 1'b0;
    end else begin
      if (enter_ack) ack_pend_q <= 1'b0;
      if (ack_en)    ack_pend_q <= 1'b1;

      if (enter_req) req_pend_q <= 1'b0;
      if (retry_hit) req_pend_q <= 1'b1;

      if (req_done) begin
        awaiting_q <= 1'b1;
        timer_q    <= '0;
        if (retry_ok) retry_cnt_q <= retry_cnt_q + 4'd1;
      end else if (timeout) begin
        awaiting_q <= 1'b0;
        timer_q    <= '0;
      end else if (awaiting_q) begin
        timer_q <= timer_q + TIME_W'(1);
      end

      if (fail_hit) begin
        retry_cnt_q <= '0;
        mac_valid   <= 1'b0;
      end
      arp_fail <= fail_hit;

      if (get_en) begin
        mac_pc      <= get_mac_pc;
        mac_valid   <= 1'b1;
        awaiting_q  <= 1'b0;
        timer_q     <= '0;
        retry_cnt_q <= '0;
        req_pend_q  <= 1'b0;
      end

      if (start) begin
        req_pend_q  <= 1'b1;
        retry_cnt_q <= '0;
        awaiting_q  <= 1'b0;
        timer_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arp_ctrl.sv
// tb_arp_ctrl - directed self-checking bench for arp_ctrl with
// RETRY_TIME=100 and MAX_RETRY=3. Inputs change 1 ns after the rising edge,
// outputs are sampled at the same point, so "cycle N" is the interval after
// edge N.
module tb_arp_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ack_en, get_en, tx_done;
  logic [47:0] get_mac_pc;
  logic        tx_start, tx_op, mac_valid, arp_fail, busy;
  logic [47:0] mac_pc;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int td, ts, ns, nf;

  always #5 clk = ~clk;

  arp_ctrl #(
    .MAC_ADDR_W(48),
    .TIME_W    (32),
    .RETRY_TIME(100),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ack_en    (ack_en),
    .get_en    (get_en),
    .get_mac_pc(get_mac_pc),
    .tx_start  (tx_start),
    .tx_op     (tx_op),
    .tx_done   (tx_done),
    .mac_pc    (mac_pc),
    .mac_valid (mac_valid),
    .arp_fail  (arp_fail),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? tx_start : arp_fail;
  endfunction

  // Advance until tx_start (sel 0) or arp_fail (sel 1) is seen, bounded.
  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!sig(sel) && n < 400) begin
      step();
      n++;
    end
    if (!sig(sel)) check(tag, 64'd0, 64'd1);
  endtask

  task automatic count_events(input int n, output int starts, output int fails);
    starts = 0;
    fails  = 0;
    repeat (n) begin
      step();
      starts += int'(tx_start);
      fails  += int'(arp_fail);
    end
  endtask

  task automatic pulse_done();
    td = cyc;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic pulse_start();
    ts = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"},  64'(tx_start),  64'd0);
    check({tag, "_tx_op"},     64'(tx_op),     64'd0);
    check({tag, "_mac_pc"},    64'(mac_pc),    64'd0);
    check({tag, "_mac_valid"}, 64'(mac_valid), 64'd0);
    check({tag, "_arp_fail"},  64'(arp_fail),  64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; ack_en = 1'b0; get_en = 1'b0; tx_done = 1'b0;
    get_mac_pc = '0;

    // Reset and idle
    step(2);
    rst = 1'b0;
    step();
    check_all_zero("reset");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tx_done = (i == 5 || i == 12);
      step();
      seen += int'(tx_start) + int'(busy) + int'(arp_fail) + int'(mac_valid) + int'(tx_op);
    end
    tx_done = 1'b0;
    check("idle_quiet", 64'(seen), 64'd0);

    // Resolution
    pulse_start();
    check("res_no_early_start", 64'(tx_start), 64'd0);
    check("res_busy", 64'(busy), 64'd1);
    step();
    check("res_tx_start_n2", 64'(tx_start), 64'd1);
    check("res_tx_op_req", 64'(tx_op), 64'd0);
    step();
    check("res_tx_start_1cyc", 64'(tx_start), 64'd0);
    step(16);
    pulse_done();
    step(19);
    get_en = 1'b1; get_mac_pc = 48'h001122334455;
    step();
    get_en = 1'b0; get_mac_pc = '0;
    check("res_mac_pc", 64'(mac_pc), 64'h001122334455);
    check("res_mac_valid", 64'(mac_valid), 64'd1);
    check("res_busy_clear", 64'(busy), 64'd0);
    count_events(150, ns, nf);
    check("res_no_more_tx", 64'(ns), 64'd0);

    // Retry and fail
    pulse_start();
    wait_for(0, "retry_first_timeout");
    check("retry_first_lat", 64'(cyc - ts), 64'd2);
    check("retry_refresh_valid", 64'(mac_valid), 64'd1);
    for (int r = 0; r < 3; r++) begin
      step(3);
      pulse_done();
      if (r < 2) begin
        wait_for(0, "retry_timeout");
        check("retry_lat", 64'(cyc - td), 64'd102);
        check("retry_tx_op", 64'(tx_op), 64'd0);
      end else begin
        wait_for(1, "fail_timeout");
        check("fail_lat", 64'(cyc - td), 64'd101);
        check("fail_mac_valid", 64'(mac_valid), 64'd0);
        check("fail_busy", 64'(busy), 64'd0);
        step();
        check("fail_one_cycle", 64'(arp_fail), 64'd0);
      end
    end
    count_events(150, ns, nf);
    check("fail_no_tx_after", 64'(ns), 64'd0);

    // Priority and coalescing
    ts = cyc;
    start = 1'b1; ack_en = 1'b1;
    step();
    start = 1'b0; ack_en = 1'b0;
    wait_for(0, "prio_timeout");
    check("prio_lat", 64'(cyc - ts), 64'd2);
    check("prio_reply_first", 64'(tx_op), 64'd1);
    step(4);
    pulse_done();
    wait_for(0, "prio_req_timeout");
    check("prio_req_lat", 64'(cyc - td), 64'd2);
    check("prio_req_second", 64'(tx_op), 64'd0);
    for (int i = 0; i < 3; i++) begin
      ack_en = 1'b1;
      step();
      ack_en = 1'b0;
      step();
    end
    pulse_done();
    wait_for(0, "coal_timeout");
    check("coal_lat", 64'(cyc - td), 64'd2);
    check("coal_reply", 64'(tx_op), 64'd1);
    step(3);
    pulse_done();
    count_events(40, ns, nf);
    check("coal_single_reply", 64'(ns), 64'd0);
    get_en = 1'b1; get_mac_pc = 48'hA0B1C2D3E4F5;
    step();
    get_en = 1'b0;
    check("coal_mac_pc", 64'(mac_pc), 64'hA0B1C2D3E4F5);
    check("coal_busy_clear", 64'(busy), 64'd0);

    // Reply sent during reply wait; timeout still relative to request tx_done
    pulse_start();
    wait_for(0, "ovl_timeout");
    step(2);
    pulse_done();
    step(19);
    ack_en = 1'b1;
    step();
    ack_en = 1'b0;
    wait_for(0, "ovl_reply_timeout");
    check("ovl_reply_lat", 64'(cyc - td), 64'd22);
    check("ovl_reply_op", 64'(tx_op), 64'd1);
    ts = td;
    step(3);
    pulse_done();
    td = ts;
    wait_for(0, "ovl_retry_timeout");
    check("ovl_retry_lat", 64'(cyc - td), 64'd102);
    check("ovl_retry_op", 64'(tx_op), 64'd0);

    // get_en on the timeout cycle
    step(2);
    pulse_done();
    step(99);
    get_en = 1'b1; get_mac_pc = 48'h0123456789AB;
    step();
    get_en = 1'b0;
    check("sim_mac_valid", 64'(mac_valid), 64'd1);
    check("sim_mac_pc", 64'(mac_pc), 64'h0123456789AB);
    check("sim_busy", 64'(busy), 64'd0);
    count_events(150, ns, nf);
    check("sim_no_retry", 64'(ns), 64'd0);
    check("sim_no_fail", 64'(nf), 64'd0);

    // ack_en on the edge entering TX_ACK, then reset mid-reply
    ts = cyc;
    ack_en = 1'b1;
    step();
    step();
    ack_en = 1'b0;
    check("ackedge_start", 64'(tx_start), 64'd1);
    check("ackedge_op", 64'(tx_op), 64'd1);
    step(3);
    pulse_done();
    wait_for(0, "ackedge_second_timeout");
    check("ackedge_second_lat", 64'(cyc - td), 64'd2);
    check("ackedge_second_op", 64'(tx_op), 64'd1);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_mid");
    step(2);
    pulse_done();
    count_events(30, ns, nf);
    check("rst_late_done_ignored", 64'(ns), 64'd0);
    check("rst_busy_after", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
ARP protocol sequencer between the ARP receive analyser and the ARP transmit packer. It consumes the analyser's per-packet strobes: ack_en means a valid request for our IP was received; get_en with get_mac_pc means a valid reply was received. It schedules outgoing ARP requests and replies onto the single transmit packer, with retry and timeout. It also holds the resolved PC MAC address for the UDP/IP transmit path.

Parameters:
MAC_ADDR_W, 48, MAC address width
TIME_W, 32, width of the reply-wait timer
RETRY_TIME, 12500000, clock cycles to wait for an ARP reply before retrying (minimum 2)
MAX_RETRY, 4, total request transmissions before declaring failure (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: resolve (or refresh) the PC MAC address
ack_en  in  1  one-cycle pulse from the receive analyser: valid ARP request received, reply required
get_en  in  1  one-cycle pulse from the receive analyser: valid ARP reply received
get_mac_pc  in  MAC_ADDR_W  sender MAC from the receive analyser; valid only while get_en=1
tx_start  out  1  one-cycle pulse to the ARP transmit packer: build and send a packet
tx_op  out  1  packet type for the packer (0 = request, 1 = reply); stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse from the packer: last word of the packet sent
mac_pc  out  MAC_ADDR_W  latched PC MAC address
mac_valid  out  1  mac_pc holds a resolved address
arp_fail  out  1  one-cycle pulse: MAX_RETRY requests sent with no reply
busy  out  1  any pending work, transmission in flight, or reply wait in progress

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears everything:
  - Outputs: tx_start=0, tx_op=0, mac_pc=0, mac_valid=0, arp_fail=0, busy=0.
  - Internal state: FSM=IDLE, ack_pend=0, req_pend=0, awaiting=0, timer=0, retry_cnt=0.
  - Reset mid-packet abandons the transfer. A tx_done arriving after reset is ignored.
- Pending flags (registered):
  - ack_pend is set by ack_en and cleared when the FSM enters TX_ACK. Repeated ack_en while pending coalesces into one reply. ack_en on the same cycle as the clearing edge keeps ack_pend=1.
  - req_pend is set by start or by a retry timeout, and cleared when the FSM enters TX_REQ.
- start:
  - Sets req_pend, clears retry_cnt, clears awaiting and timer.
  - mac_valid is unchanged, so a refresh does not invalidate the current address.
- FSM states: IDLE, TX_REQ, TX_ACK.
  - IDLE: if ack_pend, go to TX_ACK with tx_op=1. Else if req_pend, go to TX_REQ with tx_op=0. Else stay. Reply has strict priority over request.
  - tx_start is registered and high for exactly the first cycle in TX_REQ or TX_ACK.
  - TX_REQ: on tx_done, go to IDLE, set awaiting=1, timer=0, retry_cnt+1.
  - TX_ACK: on tx_done, go to IDLE. awaiting and timer are unaffected, so the wait continues while a reply is being sent.
  - tx_done in IDLE is ignored.
- Latency: with the FSM in IDLE, an ack_en or start pulse in cycle N gives tx_start in cycle N+2.
- Timer:
  - Increments every cycle while awaiting=1, in any FSM state.
  - Timeout when awaiting=1 and timer==RETRY_TIME-1. Consequences:
    - timer returns to 0 and awaiting is cleared.
    - If retry_cnt<MAX_RETRY: set req_pend.
    - Else: arp_fail=1 for one cycle, mac_valid=0, retry_cnt=0.
- get_en (accepted in any state, including gratuitous replies):
  - mac_pc<=get_mac_pc and mac_valid<=1 at the next edge.
  - Clears awaiting, timer, retry_cnt and req_pend.
  - get_en on the same cycle as a timeout: get_en wins; no retry and no arp_fail.
  - get_en on the same cycle as start: start wins for req_pend/retry_cnt/awaiting, but the MAC is still latched.
- busy = (FSM!=IDLE) | ack_pend | req_pend | awaiting, registered-equivalent (derived only from registered state).
- retry_cnt saturates at MAX_RETRY. The timer cannot exceed RETRY_TIME-1.

Test Plan:
- Reset then idle: all outputs 0 for 20 cycles; tx_done pulses in IDLE produce no tx_start.
- Resolution: RETRY_TIME=100, MAX_RETRY=3. start at cycle 10 -> tx_start=1 with tx_op=0 at cycle 12. tx_done at cycle 30. get_en at cycle 50 with get_mac_pc=48'h001122334455 -> mac_pc=48'h001122334455 and mac_valid=1 at cycle 51; busy=0 at cycle 51; no further tx_start.
- Retry/fail: same parameters, no get_en. tx_done at cycle T -> retry tx_start at T+102. After the 3rd tx_done at T3 -> arp_fail pulse at T3+101, mac_valid=0, busy=0.
- Priority/coalesce: ack_en and start on the same cycle in IDLE -> first tx_start has tx_op=1; after its tx_done, the next tx_start has tx_op=0. Three ack_en pulses while in TX_REQ -> exactly one subsequent reply.
- Wait overlap: ack_en 20 cycles into a 100-cycle wait -> reply sent. The timer keeps running, so the timeout still occurs at tx_done+100 of the request.
- Simultaneity/reset: get_en coincident with the timeout cycle -> no retry, mac_valid=1. rst=1 while in TX_ACK -> all outputs 0 at the next edge; a late tx_done is ignored.
